// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for the shared 64-bit data memory.
// One command accepted per cycle, one access cycle, registered response.
module dmem_arbiter #(
   parameter logic [63:0] DATA_START = 64'h10000000,
   parameter int unsigned DATA_WORDS = 'h1000,
   parameter int unsigned MAX_BURST  = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        p0_req,
   input  logic        p0_lock,
   input  logic        p0_word_we,
   input  logic        p0_byte_we,
   input  logic [63:0] p0_addr,
   input  logic [63:0] p0_wdata,
   output logic        p0_gnt,
   output logic        p0_rvalid,
   output logic [63:0] p0_rdata,
   output logic        p0_err,
   input  logic        p1_req,
   input  logic        p1_lock,
   input  logic        p1_word_we,
   input  logic        p1_byte_we,
   input  logic [63:0] p1_addr,
   input  logic [63:0] p1_wdata,
   output logic        p1_gnt,
   output logic        p1_rvalid,
   output logic [63:0] p1_rdata,
   output logic        p1_err,
   output logic [63:0] mem_addr,
   output logic [63:0] mem_wdata,
   output logic        mem_word_we,
   output logic        mem_byte_we,
   input  logic [63:0] mem_rdata
);

   localparam logic [63:0] DATA_END  = DATA_START + 64'(DATA_WORDS) * 64'd8;
   localparam logic [3:0]  BURST_MAX = 4'(MAX_BURST);

   logic [1:0]  req_vec;
   logic [1:0]  lock_vec;
   logic [1:0]  word_we_vec;
   logic [1:0]  byte_we_vec;
   logic [63:0] addr_arr  [2];
   logic [63:0] wdata_arr [2];

   assign req_vec      = {p1_req, p0_req};
   assign lock_vec     = {p1_lock, p0_lock};
   assign word_we_vec  = {p1_word_we, p0_word_we};
   assign byte_we_vec  = {p1_byte_we, p0_byte_we};
   assign addr_arr[0]  = p0_addr;
   assign addr_arr[1]  = p1_addr;
   assign wdata_arr[0] = p0_wdata;
   assign wdata_arr[1] = p1_wdata;

   logic        access_valid_reg;
   logic [63:0] addr_reg;
   logic [63:0] wdata_reg;
   logic        word_we_reg;
   logic        byte_we_reg;
   logic        owner_reg;
   logic        in_range_reg;
   logic        last_owner_reg;
   logic        last_lock_reg;
   logic [3:0]  burst_cnt_reg;
   logic [3:0]  burst_cnt_next;

   logic        any_req;
   logic        winner;
   logic [1:0]  gnt_vec;
   logic [63:0] win_addr;
   logic        in_range_next;

   // Nothing is accepted while reset is held, so no command is lost to the clear.
   always_comb begin
      any_req = 1'b0;
      winner  = 1'b0;
      if (!reset) begin
         case (req_vec)
            2'b01: begin
               any_req = 1'b1;
               winner  = 1'b0;
            end
            2'b10: begin
               any_req = 1'b1;
               winner  = 1'b1;
            end
            2'b11: begin
               any_req = 1'b1;
               if (last_lock_reg && (burst_cnt_reg < BURST_MAX))
                  winner = last_owner_reg;
               else
                  winner = ~last_owner_reg;
            end
            default: begin
               any_req = 1'b0;
               winner  = 1'b0;
            end
         endcase
      end
   end

   assign gnt_vec[0] = any_req & ~winner;
   assign gnt_vec[1] = any_req & winner;
   assign p0_gnt     = gnt_vec[0];
   assign p1_gnt     = gnt_vec[1];

   assign win_addr      = addr_arr[winner];
   assign in_range_next = (win_addr >= DATA_START) && (win_addr < DATA_END);

   always_comb begin
      burst_cnt_next = burst_cnt_reg;
      if (any_req) begin
         if ((winner == last_owner_reg) && last_lock_reg)
            burst_cnt_next = (burst_cnt_reg >= BURST_MAX) ? BURST_MAX : burst_cnt_reg + 4'd1;
         else
            burst_cnt_next = 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         access_valid_reg <= 1'b0;
         addr_reg         <= 64'd0;
         wdata_reg        <= 64'd0;
         word_we_reg      <= 1'b0;
         byte_we_reg      <= 1'b0;
         owner_reg        <= 1'b0;
         in_range_reg     <= 1'b0;
         last_owner_reg   <= 1'b1;
         last_lock_reg    <= 1'b0;
         burst_cnt_reg    <= 4'd0;
      end else begin
         access_valid_reg <= any_req;
         burst_cnt_reg    <= burst_cnt_next;
         if (any_req) begin
            addr_reg       <= win_addr;
            wdata_reg      <= wdata_arr[winner];
            word_we_reg    <= word_we_vec[winner];
            byte_we_reg    <= byte_we_vec[winner];
            owner_reg      <= winner;
            in_range_reg   <= in_range_next;
            last_owner_reg <= winner;
            last_lock_reg  <= lock_vec[winner];
         end
      end
   end

   // Address/data hold their last value between accesses; only the enables drop.
   assign mem_addr    = addr_reg;
   assign mem_wdata   = wdata_reg;
   assign mem_word_we = access_valid_reg & word_we_reg & in_range_reg;
   assign mem_byte_we = access_valid_reg & byte_we_reg & ~word_we_reg & in_range_reg;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : gen_resp
         logic        rvalid_reg;
         logic [63:0] rdata_reg;
         logic        err_reg;
         logic        hit;

         assign hit = access_valid_reg && (owner_reg == 1'(gi));

         always_ff @(posedge clk) begin
            if (reset) begin
               rvalid_reg <= 1'b0;
               rdata_reg  <= 64'd0;
               err_reg    <= 1'b0;
            end else begin
               rvalid_reg <= hit;
               if (hit) begin
                  rdata_reg <= in_range_reg ? mem_rdata : 64'd0;
                  err_reg   <= ~in_range_reg;
               end
            end
         end
      end
   endgenerate

   assign p0_rvalid = gen_resp[0].rvalid_reg;
   assign p0_rdata  = gen_resp[0].rdata_reg;
   assign p0_err    = gen_resp[0].err_reg;
   assign p1_rvalid = gen_resp[1].rvalid_reg;
   assign p1_rdata  = gen_resp[1].rdata_reg;
   assign p1_err    = gen_resp[1].err_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small combinational-read,
// negedge-write memory model attached to the memory side.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        p0_req, p0_lock, p0_word_we, p0_byte_we;
   logic [63:0] p0_addr, p0_wdata;
   logic        p0_gnt, p0_rvalid, p0_err;
   logic [63:0] p0_rdata;
   logic        p1_req, p1_lock, p1_word_we, p1_byte_we;
   logic [63:0] p1_addr, p1_wdata;
   logic        p1_gnt, p1_rvalid, p1_err;
   logic [63:0] p1_rdata;
   logic [63:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_word_we, mem_byte_we;

   int checks = 0;
   int errors = 0;

   logic [63:0] mem [16];

   always #5 clk = ~clk;

   assign mem_rdata = mem[mem_addr[6:3]];

   always @(negedge clk) begin
      if (mem_word_we)
         mem[mem_addr[6:3]] = mem_wdata;
      else if (mem_byte_we)
         mem[mem_addr[6:3]][{mem_addr[2:0], 3'b000} +: 8] = mem_wdata[7:0];
   end

   dmem_arbiter dut (
      .clk(clk), .reset(reset),
      .p0_req(p0_req), .p0_lock(p0_lock), .p0_word_we(p0_word_we), .p0_byte_we(p0_byte_we),
      .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid),
      .p0_rdata(p0_rdata), .p0_err(p0_err),
      .p1_req(p1_req), .p1_lock(p1_lock), .p1_word_we(p1_word_we), .p1_byte_we(p1_byte_we),
      .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid),
      .p1_rdata(p1_rdata), .p1_err(p1_err),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_word_we(mem_word_we),
      .mem_byte_we(mem_byte_we), .mem_rdata(mem_rdata)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_port(input int p, input logic req, input logic lock, input logic wwe,
                           input logic bwe, input logic [63:0] addr, input logic [63:0] wdata);
      if (p == 0) begin
         p0_req = req; p0_lock = lock; p0_word_we = wwe; p0_byte_we = bwe;
         p0_addr = addr; p0_wdata = wdata;
      end else begin
         p1_req = req; p1_lock = lock; p1_word_we = wwe; p1_byte_we = bwe;
         p1_addr = addr; p1_wdata = wdata;
      end
   endtask

   task automatic idle_all();
      set_port(0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
      set_port(1, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
   endtask

   task automatic do_reset();
      step();
      reset = 1'b1;
      idle_all();
      step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle_all();
      step();
      step();
      #1;
      checks++;
      if ({p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_err, p1_err, mem_word_we, mem_byte_we} !== 8'h00) begin
         errors++;
         $display("FAIL reset_flags: got %b want 00000000",
                  {p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_err, p1_err, mem_word_we, mem_byte_we});
      end
      checks++;
      if ({p0_rdata, p1_rdata, mem_addr, mem_wdata} !== 256'd0) begin
         errors++;
         $display("FAIL reset_data: p0_rdata %h p1_rdata %h mem_addr %h mem_wdata %h want all 0",
                  p0_rdata, p1_rdata, mem_addr, mem_wdata);
      end
      $display("reset applied");
      step();
      reset = 1'b0;
   endtask

   task automatic test_single_read();
      step();
      set_port(0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h10000008, 64'd0);
      #1;
      checks++;
      if ({p0_gnt, p1_gnt} !== 2'b10) begin
         errors++; $display("FAIL single_gnt: got %b want 10", {p0_gnt, p1_gnt});
      end
      step();
      idle_all();
      #1;
      checks++;
      if (mem_addr !== 64'h10000008 || {mem_word_we, mem_byte_we, p0_rvalid} !== 3'b000) begin
         errors++;
         $display("FAIL single_access: mem_addr %h we %b rvalid %b want 10000008 00 0",
                  mem_addr, {mem_word_we, mem_byte_we}, p0_rvalid);
      end
      step();
      checks++;
      if ({p0_rvalid, p1_rvalid, p0_err} !== 3'b100 || p0_rdata !== 64'hA5A5_0000_0000_0001) begin
         errors++;
         $display("FAIL single_resp: rvalid %b err %b rdata %h want 10 0 a5a5000000000001",
                  {p0_rvalid, p1_rvalid}, p0_err, p0_rdata);
      end
      $display("p0 read 10000008 rdata %h err %b", p0_rdata, p0_err);
   endtask

   task automatic test_contention();
      logic e0, e1, r0, r1;
      do_reset();
      for (int i = 0; i < 8; i++) begin
         step();
         if (i < 6) begin
            set_port(0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h10000010, 64'd0);
            set_port(1, 1'b1, 1'b0, 1'b0, 1'b0, 64'h10000018, 64'd0);
         end else begin
            idle_all();
         end
         #1;
         e0 = (i < 6) && (i % 2 == 0);
         e1 = (i < 6) && (i % 2 == 1);
         r0 = (i >= 2) && (i % 2 == 0);
         r1 = (i >= 2) && (i % 2 == 1);
         checks++;
         if ({p0_gnt, p1_gnt} !== {e0, e1}) begin
            errors++; $display("FAIL contention_gnt[%0d]: got %b want %b", i, {p0_gnt, p1_gnt}, {e0, e1});
         end
         checks++;
         if ({p0_rvalid, p1_rvalid} !== {r0, r1}) begin
            errors++; $display("FAIL contention_rvalid[%0d]: got %b want %b", i, {p0_rvalid, p1_rvalid}, {r0, r1});
         end
         if (r0) begin
            checks++;
            if (p0_rdata !== 64'hA5A5_0000_0000_0002) begin
               errors++; $display("FAIL contention_p0_rdata[%0d]: got %h want a5a5000000000002", i, p0_rdata);
            end
         end
         if (r1) begin
            checks++;
            if (p1_rdata !== 64'hA5A5_0000_0000_0003) begin
               errors++; $display("FAIL contention_p1_rdata[%0d]: got %h want a5a5000000000003", i, p1_rdata);
            end
         end
         $display("contention cycle %0d gnt %b rvalid %b", i, {p0_gnt, p1_gnt}, {p0_rvalid, p1_rvalid});
      end
   endtask

   task automatic test_lock();
      logic e1;
      do_reset();
      for (int i = 0; i < 14; i++) begin
         step();
         set_port(0, 1'b1, 1'b1, 1'b0, 1'b0, 64'h10000020, 64'd0);
         if (i < 8) set_port(1, 1'b1, 1'b0, 1'b0, 1'b0, 64'h10000028, 64'd0);
         else       set_port(1, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
         #1;
         e1 = (i == 4);
         checks++;
         if ({p0_gnt, p1_gnt} !== {~e1, e1}) begin
            errors++; $display("FAIL lock_gnt[%0d]: got %b want %b", i, {p0_gnt, p1_gnt}, {~e1, e1});
         end
         $display("lock cycle %0d gnt %b", i, {p0_gnt, p1_gnt});
      end
      step();
      idle_all();
      step();
      step();
   endtask

   task automatic test_byte_write();
      step();
      set_port(1, 1'b1, 1'b0, 1'b0, 1'b1, 64'h10000003, 64'hFFFF_FFFF_FFFF_FFAB);
      #1;
      checks++;
      if (p1_gnt !== 1'b1) begin
         errors++; $display("FAIL byte_gnt: got %b want 1", p1_gnt);
      end
      step();
      idle_all();
      #1;
      checks++;
      if ({mem_word_we, mem_byte_we} !== 2'b01 || mem_addr !== 64'h10000003) begin
         errors++; $display("FAIL byte_access: we %b addr %h want 01 10000003", {mem_word_we, mem_byte_we}, mem_addr);
      end
      step();
      checks++;
      if ({p1_rvalid, p1_err} !== 2'b10) begin
         errors++; $display("FAIL byte_resp: rvalid/err %b want 10", {p1_rvalid, p1_err});
      end
      $display("p1 byte write 10000003 data ab");
      set_port(1, 1'b1, 1'b0, 1'b0, 1'b0, 64'h10000000, 64'd0);
      step();
      idle_all();
      step();
      checks++;
      if (p1_rvalid !== 1'b1 || p1_rdata !== 64'hA5A5_0000_AB00_0000) begin
         errors++; $display("FAIL byte_readback: rvalid %b rdata %h want 1 a5a50000ab000000", p1_rvalid, p1_rdata);
      end
      $display("p1 read 10000000 rdata %h", p1_rdata);
      // word_we and byte_we together: the full word is written
      set_port(0, 1'b1, 1'b0, 1'b1, 1'b1, 64'h10000010, 64'h0123_4567_89AB_CDEF);
      step();
      set_port(0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h10000010, 64'd0);
      #1;
      checks++;
      if ({mem_word_we, mem_byte_we} !== 2'b10) begin
         errors++; $display("FAIL both_we_access: we %b want 10", {mem_word_we, mem_byte_we});
      end
      step();
      idle_all();
      step();
      checks++;
      if (p0_rvalid !== 1'b1 || p0_rdata !== 64'h0123_4567_89AB_CDEF) begin
         errors++; $display("FAIL both_we_readback: rvalid %b rdata %h want 1 0123456789abcdef", p0_rvalid, p0_rdata);
      end
      $display("p0 word+byte write then read 10000010 rdata %h", p0_rdata);
   endtask

   task automatic test_out_of_range();
      step();
      set_port(0, 1'b1, 1'b0, 1'b1, 1'b0, 64'h0, 64'hDEAD_BEEF_DEAD_BEEF);
      step();
      idle_all();
      #1;
      checks++;
      if ({mem_word_we, mem_byte_we} !== 2'b00 || mem_addr !== 64'd0) begin
         errors++; $display("FAIL oor_access: we %b addr %h want 00 0", {mem_word_we, mem_byte_we}, mem_addr);
      end
      step();
      checks++;
      if ({p0_rvalid, p0_err} !== 2'b11 || p0_rdata !== 64'd0) begin
         errors++; $display("FAIL oor_resp: rvalid/err %b rdata %h want 11 0", {p0_rvalid, p0_err}, p0_rdata);
      end
      $display("p0 write 0 err %b rdata %h", p0_err, p0_rdata);
      set_port(0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h10000000, 64'd0);
      step();
      idle_all();
      step();
      checks++;
      if (p0_rdata !== 64'hA5A5_0000_AB00_0000 || p0_err !== 1'b0) begin
         errors++; $display("FAIL oor_no_write: rdata %h err %b want a5a50000ab000000 0", p0_rdata, p0_err);
      end
   endtask

   task automatic test_back_to_back();
      logic [63:0] addrs [3];
      logic [63:0] rdatas [3];
      logic        errs [3];
      addrs[0] = 64'h10007FF8; rdatas[0] = 64'hA5A5_0000_0000_000F; errs[0] = 1'b0;
      addrs[1] = 64'h10008000; rdatas[1] = 64'd0;                   errs[1] = 1'b1;
      addrs[2] = 64'h0FFFFFF8; rdatas[2] = 64'd0;                   errs[2] = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         if (i < 3) set_port(0, 1'b1, 1'b0, 1'b0, 1'b0, addrs[i], 64'd0);
         else       idle_all();
         #1;
         if (i < 3) begin
            checks++;
            if (p0_gnt !== 1'b1) begin
               errors++; $display("FAIL b2b_gnt[%0d]: got %b want 1", i, p0_gnt);
            end
         end
         if (i >= 2) begin
            checks++;
            if (p0_rvalid !== 1'b1 || p0_err !== errs[i-2] || p0_rdata !== rdatas[i-2]) begin
               errors++;
               $display("FAIL b2b_resp[%0d]: rvalid %b err %b rdata %h want 1 %b %h",
                        i - 2, p0_rvalid, p0_err, p0_rdata, errs[i-2], rdatas[i-2]);
            end
            $display("p0 read %h err %b rdata %h", addrs[i-2], p0_err, p0_rdata);
         end
      end
   endtask

   task automatic test_reset_during_access();
      step();
      set_port(1, 1'b1, 1'b0, 1'b0, 1'b0, 64'h10000008, 64'd0);
      step();
      idle_all();
      reset = 1'b1;
      #1;
      checks++;
      if (mem_addr !== 64'h10000008) begin
         errors++; $display("FAIL rst_access_addr: got %h want 10000008", mem_addr);
      end
      step();
      reset = 1'b0;
      #1;
      checks++;
      if ({p0_rvalid, p1_rvalid, mem_word_we, mem_byte_we} !== 4'b0000 || mem_addr !== 64'd0
          || p1_rdata !== 64'd0 || p0_rdata !== 64'd0) begin
         errors++;
         $display("FAIL rst_access_clear: rvalid %b we %b addr %h rdata %h/%h want 00 00 0 0/0",
                  {p0_rvalid, p1_rvalid}, {mem_word_we, mem_byte_we}, mem_addr, p0_rdata, p1_rdata);
      end
      step();
      checks++;
      if ({p0_rvalid, p1_rvalid} !== 2'b00) begin
         errors++; $display("FAIL rst_access_norvalid: got %b want 00", {p0_rvalid, p1_rvalid});
      end
      $display("reset during access: response discarded");
   endtask

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 64'hA5A5_0000_0000_0000 | 64'(i);
      test_reset();
      test_single_read();
      test_contention();
      test_lock();
      test_byte_write();
      test_out_of_range();
      test_back_to_back();
      test_reset_during_access();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
